fifo_burst_drain: RTL and testbench
===================================

Name: fifo_burst_drain

Overview:
- Drains the shared 128-bit, 1024-deep video line FIFO into the frame-buffer memory write port in fixed-length bursts.
- Tracks FIFO occupancy itself, issues one command per burst, then streams that burst's words out with backpressure.
- Generates frame-buffer addresses that wrap per frame.
- Sits between the video synch write path (the FIFO producer) and the memory controller.

Parameters:
- BURST_LEN, 16: words (128-bit) per full burst; range 1..64.
- ADDR_W, 32: memory byte-address width.
- BASE_ADDR, 32'h0000_0000: frame-buffer start byte address.
- FRAME_WORDS, 32400: 128-bit words per frame; must be a multiple of BURST_LEN.
- AFULL_THR, 1000: occupancy at which afull asserts.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- fifo_wr_en  in  1  snoop of the producer's FIFO write strobe.
- fifo_dout  in  128  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag; sanity only.
- fifo_rd_en  out  1  FIFO read strobe.
- frame_start  in  1  pulse: next burst restarts at BASE_ADDR.
- flush  in  1  pulse: drain the residual (<BURST_LEN) words as a short burst.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  memory accepts command.
- cmd_addr  out  ADDR_W  burst start byte address.
- cmd_len  out  7  words in this burst, 1..BURST_LEN.
- wdata  out  128  write data.
- wdata_valid  out  1  write data valid.
- wdata_ready  in  1  memory accepts wdata.
- level  out  11  tracked FIFO occupancy.
- afull  out  1  level >= AFULL_THR.
- busy  out  1  state != IDLE or output buffer non-empty.

Behaviour:
- Reset (synchronous) gives:
  - state=IDLE; level=0; addr=BASE_ADDR.
  - All outputs 0, except cmd_addr=BASE_ADDR.
  - Pending flush and frame_start flags cleared; skid buffer and in-flight flag cleared.
  - Reset mid-burst abandons the burst. FIFO contents are not touched by this block; the FIFO is reset by the same rst upstream.
- Level counter:
  - +1 on fifo_wr_en, -1 on fifo_rd_en; both in the same cycle leaves it unchanged.
  - Saturates at 0 and 2047.
  - afull is registered from level.
- Pending flags:
  - frame_start and flush each set a sticky flag.
  - Both flags are consumed only in IDLE.
- State machine:
  - IDLE:
    - If frame_start is pending: addr<=BASE_ADDR and clear the flag, in the same cycle as any transition.
    - If level >= BURST_LEN: len=BURST_LEN, go to CMD.
    - Else if flush is pending and level>0: len=level, clear flush, go to CMD.
    - Else if flush is pending and level==0: clear flush, stay in IDLE.
  - CMD:
    - cmd_valid=1, with cmd_addr and cmd_len held stable.
    - On cmd_ready: go to DATA, with beats_rd=len and beats_out=len.
  - DATA:
    - fifo_rd_en=1 when beats_rd>0 and (skid_count + inflight - pop) < 2, where pop = wdata_valid & wdata_ready. beats_rd decrements on each read.
    - Returning data enters a 2-entry skid buffer; wdata/wdata_valid present its head.
    - Each pop decrements beats_out.
    - When beats_out reaches 0: addr += len*16. If the new addr >= BASE_ADDR + FRAME_WORDS*16, addr <= BASE_ADDR. Then go to IDLE.
- Latency:
  - Minimum 1 cycle from level reaching BURST_LEN to cmd_valid.
  - First wdata_valid appears 2 cycles after cmd_ready.
  - With wdata_ready held high: 1 word per cycle, no bubbles.
- Boundary conditions:
  - wdata_ready low freezes wdata; no word may be lost or duplicated.
  - fifo_rd_en must never assert while level==0. If fifo_empty is set while fifo_rd_en is asserted, the sticky debug flag err is set (internal, visible to the bench).
  - flush and a full burst ready in the same cycle: the full burst wins; flush stays pending.
  - frame_start arriving during CMD or DATA does not affect the current burst.

Decomposition:
- Shared package contents:
  - State enum (IDLE, CMD, DATA).
  - WORD_BYTES=16.
  - LEVEL_W=11.
- Natural sub-module: fifo_skid2, a 2-entry 128-bit skid buffer with push, pop and count.
- Level counter and address generator stay inline.

Test Plan:
- Write 16 words (0..15) with wdata_ready=1 -> one cmd, addr=BASE_ADDR, len=16; wdata 0..15 on 16 consecutive cycles; level returns to 0; next cmd_addr=BASE_ADDR+256.
- Write 16 words; wdata_ready toggles 1-0-1-0 -> exactly 16 accepted beats in order; wdata stable while ready=0.
- Write 5 words, then flush -> cmd len=5, 5 beats; then flush with level=0 -> no cmd.
- FRAME_WORDS=32, BURST_LEN=16; write 48 words -> cmd_addr sequence 0x000, 0x100, 0x000 (wrap).
- frame_start during DATA of burst 1 -> burst 1 completes unchanged; burst 2 cmd_addr=BASE_ADDR.
- rst asserted mid-DATA -> next cycle: state IDLE, all outputs 0, level 0, cmd_addr=BASE_ADDR; no further fifo_rd_en.

Source files
------------

// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and constants for the line-FIFO burst drainer.
package fifo_burst_drain_pkg;
   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
   localparam int WORD_BYTES = 16;
   localparam int LEVEL_W    = 11;
   localparam int DATA_W     = 128;
   localparam int LEN_W      = 7;
endpackage

// File: rtl/fifo_burst_drain_if.sv
// Memory write port: burst command channel plus write-data channel.
interface fifo_burst_drain_if #(parameter int ADDR_W = 32);
   import fifo_burst_drain_pkg::*;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [LEN_W-1:0]     cmd_len;
   logic [DATA_W-1:0]    wdata;
   logic                 wdata_valid;
   logic                 wdata_ready;

   modport master (output cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid,
                   input  cmd_ready, wdata_ready);
   modport slave  (input  cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid,
                   output cmd_ready, wdata_ready);
endinterface

// File: rtl/fifo_burst_drain_skid2.sv
// Two-entry flow-through skid buffer: when empty, an incoming word is
// presented immediately on head so a freshly read FIFO word costs no extra
// cycle; it is only stored if the consumer does not take it.
module fifo_burst_drain_skid2
   import fifo_burst_drain_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        count
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr, rd_ptr;
   logic              do_wr, do_rd;

   assign do_wr = push & ~(pop & (count == 2'd0));
   assign do_rd = pop & (count != 2'd0);
   assign valid = (count != 2'd0) | push;
   assign head  = !valid ? '0 : (count != 2'd0) ? mem[rd_ptr] : push_data;

   // storage array; contents are don't-care while count says empty
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= push_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_wr) wr_ptr <= ~wr_ptr;
         if (do_rd) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_wr} - {1'b0, do_rd};
      end
   end
endmodule

// File: rtl/fifo_burst_drain.sv
// Drains the video line FIFO into the frame-buffer write port in bursts.
// Occupancy is tracked locally from the producer's write strobe and our own
// reads; addresses advance per burst and wrap at the end of the frame.
module fifo_burst_drain
   import fifo_burst_drain_pkg::*;
#(
   parameter int                BURST_LEN   = 16,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                FRAME_WORDS = 32400,
   parameter int                AFULL_THR   = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_wr_en,
   input  logic [DATA_W-1:0]    fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic                 frame_start,
   input  logic                 flush,
   fifo_burst_drain_if.master   mem,
   output logic [LEVEL_W-1:0]   level,
   output logic                 afull,
   output logic                 busy
);
   localparam logic [LEVEL_W-1:0] BURST_LVL = LEVEL_W'(BURST_LEN);
   localparam logic [LEN_W-1:0]   BURST_L   = LEN_W'(BURST_LEN);
   localparam logic [LEVEL_W-1:0] AFULL_LVL = LEVEL_W'(AFULL_THR);
   localparam logic [ADDR_W:0]    FRAME_END = (ADDR_W+1)'(BASE_ADDR)
                                            + (ADDR_W+1)'(FRAME_WORDS * WORD_BYTES);

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q, addr_next;
   logic [ADDR_W:0]    addr_sum;
   logic [LEN_W-1:0]   len_q, beats_rd, beats_out;
   logic               cmd_valid_q, fs_pend, fl_pend, inflight_q, err;
   logic [LEVEL_W-1:0] level_q, level_n;
   logic               afull_q;
   logic               pop, rd_en, skid_valid;
   logic [DATA_W-1:0]  skid_head;
   logic [1:0]         skid_cnt;
   logic [2:0]         occ;

   // words held after this cycle if we issue no new read
   assign occ   = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, pop};
   assign pop   = skid_valid & mem.wdata_ready;
   assign rd_en = ~rst & (state_q == DATA) & (beats_rd != '0)
                & (level_q != '0) & (occ < 3'd2);

   // end-of-burst address with frame wrap
   assign addr_sum  = (ADDR_W+1)'(addr_q) + (ADDR_W+1)'(len_q) * (ADDR_W+1)'(WORD_BYTES);
   assign addr_next = (addr_sum >= FRAME_END) ? BASE_ADDR : addr_sum[ADDR_W-1:0];

   // next occupancy, saturating at both ends
   always_comb begin
      level_n = level_q;
      if (fifo_wr_en & ~rd_en & (level_q != '1))
         level_n = level_q + LEVEL_W'(1);
      else if (~fifo_wr_en & rd_en & (level_q != '0))
         level_n = level_q - LEVEL_W'(1);
   end

   // occupancy, almost-full, read-in-flight and sticky read-while-empty flag
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q    <= '0;
         afull_q    <= 1'b0;
         inflight_q <= 1'b0;
         err        <= 1'b0;
      end else begin
         level_q    <= level_n;
         afull_q    <= (level_n >= AFULL_LVL);
         inflight_q <= rd_en;
         err        <= err | (rd_en & fifo_empty);
      end
   end

   // burst sequencer: pending requests, address, command and beat counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= BASE_ADDR;
         len_q       <= '0;
         beats_rd    <= '0;
         beats_out   <= '0;
         cmd_valid_q <= 1'b0;
         fs_pend     <= 1'b0;
         fl_pend     <= 1'b0;
      end else begin
         fs_pend <= fs_pend | frame_start;
         fl_pend <= fl_pend | flush;
         unique case (state_q)
            IDLE: begin
               if (fs_pend) begin
                  addr_q  <= BASE_ADDR;
                  fs_pend <= frame_start;
               end
               // a full burst takes priority; flush stays pending
               if (level_q >= BURST_LVL) begin
                  len_q       <= BURST_L;
                  cmd_valid_q <= 1'b1;
                  state_q     <= CMD;
               end else if (fl_pend) begin
                  fl_pend <= flush;
                  if (level_q != '0) begin
                     len_q       <= level_q[LEN_W-1:0];
                     cmd_valid_q <= 1'b1;
                     state_q     <= CMD;
                  end
               end
            end
            CMD: begin
               if (mem.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  beats_rd    <= len_q;
                  beats_out   <= len_q;
                  state_q     <= DATA;
               end
            end
            DATA: begin
               if (rd_en) beats_rd <= beats_rd - LEN_W'(1);
               if (pop) begin
                  beats_out <= beats_out - LEN_W'(1);
                  if (beats_out == LEN_W'(1)) begin
                     addr_q  <= addr_next;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fifo_burst_drain_skid2 u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (fifo_dout),
      .pop       (pop),
      .valid     (skid_valid),
      .head      (skid_head),
      .count     (skid_cnt)
   );

   assign fifo_rd_en      = rd_en;
   assign mem.cmd_valid   = cmd_valid_q;
   assign mem.cmd_addr    = addr_q;
   assign mem.cmd_len     = len_q;
   assign mem.wdata       = skid_head;
   assign mem.wdata_valid = skid_valid;
   assign level           = level_q;
   assign afull           = afull_q;
   assign busy            = (state_q != IDLE) | (skid_cnt != 2'd0);
endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: stimulus pushes expected commands
// and data words, a negedge monitor pops and compares on every handshake.
module tb_fifo_burst_drain;
   import fifo_burst_drain_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic         clk = 1'b0, rst = 1'b1;
   logic         fifo_wr_en = 1'b0, fifo_empty = 1'b1;
   logic         frame_start = 1'b0, flush = 1'b0;
   logic [127:0] fifo_dout = '0, wr_data = '0;
   logic         fifo_rd_en, afull, busy;
   logic [10:0]  level;

   fifo_burst_drain_if #(.ADDR_W(32)) mem_if();

   fifo_burst_drain #(
      .BURST_LEN(16), .ADDR_W(32), .BASE_ADDR(BASE),
      .FRAME_WORDS(32), .AFULL_THR(20)
   ) dut (
      .clk(clk), .rst(rst), .fifo_wr_en(fifo_wr_en), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .frame_start(frame_start), .flush(flush), .mem(mem_if.master),
      .level(level), .afull(afull), .busy(busy)
   );

   always #5 clk = ~clk;

   int           cyc = 0;
   int           n_cmp = 0, n_err = 0, n_cmd = 0, cmd_cyc = 0;
   int           rdy_mode = 0;   // 0: ready high, 1: toggle, 2: held low
   int           pop_cyc[$];
   logic [127:0] fq[$];
   logic [31:0]  exp_addr[$];
   logic [6:0]   exp_len[$];
   logic [127:0] exp_data[$];
   logic         held_v = 1'b0;
   logic [127:0] held_d = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk); cyc++;
   end

   // FIFO model: read data appears the cycle after fifo_rd_en
   initial forever begin
      @(posedge clk);
      if (rst) begin
         fq.delete();
         fifo_dout <= '0;
      end else begin
         if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
         if (fifo_wr_en) fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   // write-data backpressure pattern
   initial begin
      mem_if.wdata_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       mem_if.wdata_ready = 1'b1;
            1:       mem_if.wdata_ready = ~mem_if.wdata_ready;
            default: mem_if.wdata_ready = 1'b0;
         endcase
      end
   end

   // monitor: compare every handshake against the scoreboard
   initial forever begin
      @(negedge clk);
      if (rst) held_v = 1'b0;
      else begin
         if (held_v) begin
            check("hold_valid", mem_if.wdata_valid, 1);
            check("hold_wdata", mem_if.wdata, held_d);
         end
         if (mem_if.cmd_valid && mem_if.cmd_ready) begin
            n_cmd++;
            cmd_cyc = cyc;
            if (exp_addr.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL cmd_unexpected: got addr %0h len %0d expected none",
                        mem_if.cmd_addr, mem_if.cmd_len);
            end else begin
               check("cmd_addr", mem_if.cmd_addr, exp_addr.pop_front());
               check("cmd_len", mem_if.cmd_len, exp_len.pop_front());
            end
         end
         if (mem_if.wdata_valid && mem_if.wdata_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_data.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL wdata_unexpected: got %0h expected none", mem_if.wdata);
            end else check("wdata", mem_if.wdata, exp_data.pop_front());
         end
         held_v = mem_if.wdata_valid & ~mem_if.wdata_ready;
         held_d = mem_if.wdata;
      end
   end

   task automatic push_cmd(input logic [31:0] a, input logic [6:0] l);
      exp_addr.push_back(a);
      exp_len.push_back(l);
   endtask

   task automatic write_words(input int n, input int tag, input int fl_idx, input int fs_idx);
      for (int i = 0; i < n; i++) begin
         fifo_wr_en  = 1'b1;
         wr_data     = {8'(tag), 88'h0, 32'(i)};
         exp_data.push_back(wr_data);
         flush       = (i == fl_idx);
         frame_start = (i == fs_idx);
         tick();
      end
      fifo_wr_en = 1'b0; flush = 1'b0; frame_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while ((exp_addr.size() != 0 || exp_data.size() != 0 || busy) && k < 2000) begin
         tick(); k++;
      end
      n_cmp++;
      if (k >= 2000) begin
         n_err++;
         $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_data.size());
      end
      tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctrl"}, {mem_if.cmd_valid, mem_if.cmd_len, mem_if.wdata_valid,
                             fifo_rd_en, afull, busy}, 0);
      check({tag, "_addr"}, mem_if.cmd_addr, BASE);
      check({tag, "_wdata"}, mem_if.wdata, 0);
      check({tag, "_level"}, level, 0);
   endtask

   initial begin
      int c0, k, n;
      mem_if.cmd_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check_reset("reset");

      // T1: one full burst at full rate
      pop_cyc.delete();
      push_cmd(BASE, 16);
      write_words(16, 1, -1, -1);
      wait_done("t1");
      check("t1_beats", pop_cyc.size(), 16);
      if (pop_cyc.size() == 16) begin
         check("t1_first_lat", pop_cyc[0] - cmd_cyc, 2);
         check("t1_no_bubble", pop_cyc[15] - pop_cyc[0], 15);
      end
      check("t1_level", level, 0);
      check("t1_next_addr", mem_if.cmd_addr, BASE + 32'h100);

      // T2: toggling backpressure, burst ends at frame end and wraps
      rdy_mode = 1;
      push_cmd(BASE + 32'h100, 16);
      write_words(16, 2, -1, -1);
      wait_done("t2");
      rdy_mode = 0;
      check("t2_wrap_addr", mem_if.cmd_addr, BASE);

      // T3: short burst on flush, then flush with nothing buffered
      push_cmd(BASE, 5);
      write_words(5, 3, -1, -1);
      flush = 1'b1; tick(); flush = 1'b0;
      wait_done("t3");
      c0 = n_cmd;
      flush = 1'b1; tick(); flush = 1'b0;
      repeat (20) tick();
      check("t3_no_cmd", n_cmd, c0);
      check("t3_addr", mem_if.cmd_addr, BASE + 32'h50);
      check("t3_busy", busy, 0);

      // T4: realign with frame_start, then 48 words wrap the 2-burst frame
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      push_cmd(BASE, 16); push_cmd(BASE + 32'h100, 16); push_cmd(BASE, 16);
      write_words(48, 4, -1, -1);
      wait_done("t4");

      // T5: frame_start during burst 2 leaves it alone, burst 3 restarts
      push_cmd(BASE + 32'h100, 16); push_cmd(BASE, 16); push_cmd(BASE, 16);
      write_words(48, 5, -1, 44);
      wait_done("t5");
      check("t5_addr", mem_if.cmd_addr, BASE + 32'h100);

      // T6: reset in the middle of a stalled burst
      rdy_mode = 2;
      push_cmd(BASE + 32'h100, 16);
      write_words(16, 6, -1, -1);
      k = 0;
      while (!mem_if.wdata_valid && k < 100) begin tick(); k++; end
      check("t6_in_data", mem_if.wdata_valid, 1);
      exp_data.delete();
      rst = 1'b1; tick(); rst = 1'b0;
      rdy_mode = 0;
      check_reset("t6");
      n = 0;
      repeat (10) begin
         if (fifo_rd_en) n++;
         tick();
      end
      check("t6_no_rd", n, 0);

      // T7: flush arrives with a full burst ready; full burst first
      mem_if.cmd_ready = 1'b0;
      push_cmd(BASE, 16); push_cmd(BASE + 32'h100, 4);
      write_words(20, 7, 15, -1);
      tick();
      check("t7_level", level, fq.size());
      check("t7_afull", afull, 1);
      check("t7_cmd_held", {mem_if.cmd_valid, mem_if.cmd_len}, {1'b1, 7'd16});
      mem_if.cmd_ready = 1'b1;
      wait_done("t7");
      check("t7_addr", mem_if.cmd_addr, BASE + 32'h140);
      check("t7_afull_clr", afull, 0);

      check("queues_empty", exp_addr.size() + exp_data.size(), 0);
      check("err_flag", dut.err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
